// File: rtl/wishbone_pkg.sv
// Shared Wishbone types: cycle-type / burst enums and the response token
// that travels down the target response delay line.
package wishbone_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    // Tokens carry a fixed-width tag field; targets use the low TGDWidth bits.
    localparam int unsigned TgdMaxWidth = 16;

    typedef struct packed {
        logic                   valid;
        logic                   is_err;
        logic                   is_read;
        logic [TgdMaxWidth-1:0] tgd;
    } resp_tok_t;

    localparam resp_tok_t RespTokIdle = '0;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wishbone_response_pipe.sv
// Fixed-latency response delay line for a pipelined Wishbone target.
// A synchronous flush empties every stage on the next clock edge.
module wishbone_response_pipe
    import wishbone_pkg::*;
#(
    parameter int unsigned Stages    = 1,
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  resp_tok_t            in_tok,
    input  logic [DataWidth-1:0] in_data,
    output resp_tok_t            out_tok,
    output logic [DataWidth-1:0] out_data
);

    resp_tok_t            tok_q  [Stages];
    resp_tok_t            tok_d  [Stages];
    logic [DataWidth-1:0] data_q [Stages];
    logic [DataWidth-1:0] data_d [Stages];

    always_comb begin
        for (int i = 0; i < Stages; i++) begin
            tok_d[i]  = RespTokIdle;
            data_d[i] = '0;
        end
        if (!flush) begin
            tok_d[0]  = in_tok;
            data_d[0] = in_data;
            for (int i = 1; i < Stages; i++) begin
                tok_d[i]  = tok_q[i-1];
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Stages; i++) begin
                tok_q[i]  <= RespTokIdle;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Stages; i++) begin
                tok_q[i]  <= tok_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_tok  = tok_q[Stages-1];
    assign out_data = data_q[Stages-1];

endmodule

// File: rtl/wishbone_target_ram.sv
// Pipelined Wishbone target RAM with per-lane writes and fixed response latency.
// Define WISHBONE_TARGET_RAM_ERR_EN to answer addresses >= Depth with ERR.
module wishbone_target_ram
    import wishbone_pkg::*;
#(
    parameter int unsigned AddressWidth = 16,
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned Granularity  = 8,
    parameter int unsigned TGDWidth     = 1,
    parameter int unsigned Depth        = 256,
    parameter int unsigned WaitStates   = 0,
    localparam int unsigned SELWidth    = DataWidth / Granularity
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CYC,
    input  logic                    STB,
    input  logic                    WE,
    input  logic [AddressWidth-1:0] ADDR,
    input  logic [SELWidth-1:0]     SEL,
    input  logic [DataWidth-1:0]    DAT_ToTarget,
    input  logic [TGDWidth-1:0]     TGD_ToTarget,
    input  logic                    ForceStall,
    output logic [DataWidth-1:0]    DAT_ToInitiator,
    output logic [TGDWidth-1:0]     TGD_ToInitiator,
    output logic                    ACK,
    output logic                    ERR,
    output logic                    RTY,
    output logic                    STALL
);

    localparam int unsigned IdxWidth = clog2_min1(Depth);
    localparam int unsigned Stages   = 1 + WaitStates;

    logic [DataWidth-1:0] mem [Depth];

    logic                 accept;
    logic                 out_of_range;
    logic                 commit_wr;
    logic [IdxWidth-1:0]  idx;
    logic [DataWidth-1:0] rd_word;
    logic [DataWidth-1:0] req_data;
    resp_tok_t            req_tok;
    resp_tok_t            rsp_tok;
    logic [DataWidth-1:0] rsp_data;

    logic [DataWidth-1:0] dat_q;
    logic [DataWidth-1:0] dat_d;
    logic [TGDWidth-1:0]  tgd_q;
    logic [TGDWidth-1:0]  tgd_d;

    logic                 unused_bits;

    assign STALL  = ForceStall;
    assign RTY    = 1'b0;
    assign accept = CYC & STB & ~ForceStall & ~RST;
    assign idx    = ADDR[IdxWidth-1:0];

`ifdef WISHBONE_TARGET_RAM_ERR_EN
    assign out_of_range = ({1'b0, ADDR} >= (AddressWidth+1)'(Depth));
`else
    assign out_of_range = 1'b0;
`endif

    assign commit_wr = accept & WE & ~out_of_range;
    assign rd_word   = mem[idx];

    // Reads sample the array in the accept cycle, so a write committed on
    // the previous edge is already visible here.
    always_comb begin
        req_tok         = RespTokIdle;
        req_tok.valid   = accept;
        req_tok.is_err  = out_of_range;
        req_tok.is_read = ~WE;
        req_tok.tgd     = TgdMaxWidth'(TGD_ToTarget);
        req_data        = '0;
        if (!WE && !out_of_range) begin
            req_data = rd_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (commit_wr) begin
            for (int l = 0; l < SELWidth; l++) begin
                if (SEL[l]) begin
                    mem[idx][l*Granularity +: Granularity]
                        <= DAT_ToTarget[l*Granularity +: Granularity];
                end
            end
        end
    end

    wishbone_response_pipe #(
        .Stages    (Stages),
        .DataWidth (DataWidth)
    ) u_rsp_pipe (
        .clk      (CLK),
        .rst      (RST),
        .flush    (~CYC),
        .in_tok   (req_tok),
        .in_data  (req_data),
        .out_tok  (rsp_tok),
        .out_data (rsp_data)
    );

    assign ACK = rsp_tok.valid & ~rsp_tok.is_err;
    assign ERR = rsp_tok.valid & rsp_tok.is_err;

    always_comb begin
        dat_d = dat_q;
        tgd_d = tgd_q;
        if (ACK && rsp_tok.is_read) begin
            dat_d = rsp_data;
        end
        if (rsp_tok.valid) begin
            tgd_d = rsp_tok.tgd[TGDWidth-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dat_q <= '0;
            tgd_q <= '0;
        end else begin
            dat_q <= dat_d;
            tgd_q <= tgd_d;
        end
    end

    assign DAT_ToInitiator = dat_d;
    assign TGD_ToInitiator = tgd_d;

    assign unused_bits = ^{ADDR, rsp_tok.tgd};

endmodule

// File: tb/tb_wishbone_target_ram.sv
// Directed bench: one 8-bit zero-wait target and one 32-bit two-wait target.
// Expectations depend on WISHBONE_TARGET_RAM_ERR_EN where noted.
module tb_wishbone_target_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_rst, a_cyc, a_stb, a_we, a_fs;
    logic [15:0] a_addr;
    logic [0:0]  a_sel;
    logic [7:0]  a_dati, a_dato;
    logic [0:0]  a_tgdi, a_tgdo;
    logic        a_ack, a_err, a_rty, a_stall;

    logic        b_rst, b_cyc, b_stb, b_we, b_fs;
    logic [15:0] b_addr;
    logic [3:0]  b_sel;
    logic [31:0] b_dati, b_dato;
    logic [3:0]  b_tgdi, b_tgdo;
    logic        b_ack, b_err, b_rty, b_stall;

    wishbone_target_ram #(
        .AddressWidth (16), .DataWidth (8), .Granularity (8),
        .TGDWidth (1), .Depth (256), .WaitStates (0)
    ) u_a (
        .CLK (clk), .RST (a_rst), .CYC (a_cyc), .STB (a_stb), .WE (a_we),
        .ADDR (a_addr), .SEL (a_sel), .DAT_ToTarget (a_dati),
        .TGD_ToTarget (a_tgdi), .ForceStall (a_fs),
        .DAT_ToInitiator (a_dato), .TGD_ToInitiator (a_tgdo),
        .ACK (a_ack), .ERR (a_err), .RTY (a_rty), .STALL (a_stall)
    );

    wishbone_target_ram #(
        .AddressWidth (16), .DataWidth (32), .Granularity (8),
        .TGDWidth (4), .Depth (256), .WaitStates (2)
    ) u_b (
        .CLK (clk), .RST (b_rst), .CYC (b_cyc), .STB (b_stb), .WE (b_we),
        .ADDR (b_addr), .SEL (b_sel), .DAT_ToTarget (b_dati),
        .TGD_ToTarget (b_tgdi), .ForceStall (b_fs),
        .DAT_ToInitiator (b_dato), .TGD_ToInitiator (b_tgdo),
        .ACK (b_ack), .ERR (b_err), .RTY (b_rty), .STALL (b_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic cyc, input logic stb, input logic we,
                         input logic [15:0] addr, input logic [7:0] dat,
                         input logic [0:0] sel, input logic [0:0] tgd);
        a_cyc = cyc; a_stb = stb; a_we = we; a_addr = addr;
        a_dati = dat; a_sel = sel; a_tgdi = tgd;
    endtask

    task automatic b_req(input logic cyc, input logic stb, input logic we,
                         input logic [15:0] addr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [3:0] tgd);
        b_cyc = cyc; b_stb = stb; b_we = we; b_addr = addr;
        b_dati = dat; b_sel = sel; b_tgdi = tgd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; a_fs = 1'b0;
        b_rst = 1'b1; b_fs = 1'b0;
        a_req(0, 0, 0, 16'h0, 8'h0, 1'b0, 1'b0);
        b_req(0, 0, 0, 16'h0, 32'h0, 4'h0, 4'h0);
        tick();
        tick();
        chk("a_rst_ack", a_ack, 0);
        chk("a_rst_err", a_err, 0);
        chk("a_rst_rty", a_rty, 0);
        chk("a_rst_dat", a_dato, 0);
        chk("a_rst_tgd", a_tgdo, 0);
        chk("b_rst_ack", b_ack, 0);
        chk("b_rst_dat", b_dato, 0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        tick();

        // 8-bit, zero wait: write then immediate read of same address
        a_req(1, 1, 1, 16'h0010, 8'hA5, 1'b1, 1'b1);
        chk("a_wr_pre_ack", a_ack, 0);
        tick();
        chk("a_wr_ack", a_ack, 1);
        chk("a_wr_err", a_err, 0);
        chk("a_wr_tgd", a_tgdo, 1);
        a_req(1, 1, 0, 16'h0010, 8'h00, 1'b1, 1'b0);
        tick();
        chk("a_rd_ack", a_ack, 1);
        chk("a_rd_dat", a_dato, 8'hA5);
        chk("a_rd_tgd", a_tgdo, 0);
        a_req(1, 0, 0, 16'h0, 8'h0, 1'b1, 1'b0);
        tick();
        chk("a_idle_ack", a_ack, 0);
        chk("a_hold_dat", a_dato, 8'hA5);

        // ForceStall holds off acceptance for three cycles
        a_req(1, 1, 1, 16'h0011, 8'h5A, 1'b1, 1'b0);
        tick();
        a_fs = 1'b1;
        a_req(1, 1, 0, 16'h0011, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("a_stall_out", a_stall, 1);
            tick();
            chk("a_stall_noack", a_ack, 0);
        end
        a_fs = 1'b0;
        chk("a_stall_rel", a_stall, 0);
        tick();
        chk("a_stall_ack", a_ack, 1);
        chk("a_stall_dat", a_dato, 8'h5A);
        chk("a_stall_tgd", a_tgdo, 1);
        a_req(1, 0, 0, 16'h0, 8'h0, 1'b1, 1'b0);
        tick();
        chk("a_stall_once", a_ack, 0);

        // SEL of zero: acknowledged, storage untouched
        a_req(1, 1, 1, 16'h0010, 8'hFF, 1'b0, 1'b0);
        tick();
        chk("a_sel0_ack", a_ack, 1);
        a_req(1, 1, 0, 16'h0010, 8'h00, 1'b1, 1'b0);
        tick();
        chk("a_sel0_dat", a_dato, 8'hA5);

        // Out-of-range address
        a_req(1, 1, 1, 16'h0000, 8'h3C, 1'b1, 1'b0);
        tick();
        chk("a_base_ack", a_ack, 1);
        a_req(1, 1, 1, 16'h0100, 8'h77, 1'b1, 1'b1);
        tick();
`ifdef WISHBONE_TARGET_RAM_ERR_EN
        chk("a_oor_err", a_err, 1);
        chk("a_oor_ack", a_ack, 0);
`else
        chk("a_oor_err", a_err, 0);
        chk("a_oor_ack", a_ack, 1);
`endif
        chk("a_oor_tgd", a_tgdo, 1);
        a_req(1, 1, 0, 16'h0000, 8'h00, 1'b1, 1'b0);
        tick();
        chk("a_alias_ack", a_ack, 1);
`ifdef WISHBONE_TARGET_RAM_ERR_EN
        chk("a_alias_dat", a_dato, 8'h3C);
`else
        chk("a_alias_dat", a_dato, 8'h77);
`endif
        a_req(0, 0, 0, 16'h0, 8'h0, 1'b0, 1'b0);
        tick();
        chk("a_end_ack", a_ack, 0);
        chk("a_end_err", a_err, 0);

        // 32-bit, two waits: lane write merge
        b_req(1, 1, 1, 16'h0004, 32'h11223344, 4'hF, 4'h0);
        tick();
        chk("b_m1_ack", b_ack, 0);
        b_req(1, 1, 1, 16'h0004, 32'hFFFFFFFF, 4'b0010, 4'h0);
        tick();
        chk("b_m2_ack", b_ack, 0);
        b_req(1, 1, 0, 16'h0004, 32'h0, 4'hF, 4'h9);
        tick();
        chk("b_m_w1_ack", b_ack, 1);
        chk("b_m_w1_dat", b_dato, 0);
        b_req(1, 0, 0, 16'h0, 32'h0, 4'h0, 4'h0);
        tick();
        chk("b_m_w2_ack", b_ack, 1);
        tick();
        chk("b_m_rd_ack", b_ack, 1);
        chk("b_m_rd_dat", b_dato, 32'h1122FF44);
        chk("b_m_rd_tgd", b_tgdo, 4'h9);
        tick();
        chk("b_m_idle", b_ack, 0);
        chk("b_m_hold", b_dato, 32'h1122FF44);

        // Fill 5..7 and 8, drain
        b_req(1, 1, 1, 16'h0005, 32'h55555555, 4'hF, 4'h0);
        tick();
        b_req(1, 1, 1, 16'h0006, 32'h66666666, 4'hF, 4'h0);
        tick();
        b_req(1, 1, 1, 16'h0007, 32'h77777777, 4'hF, 4'h0);
        tick();
        b_req(1, 1, 1, 16'h0008, 32'hCAFEF00D, 4'hF, 4'h0);
        tick();
        b_req(1, 0, 0, 16'h0, 32'h0, 4'h0, 4'h0);
        tick();
        tick();
        tick();
        chk("b_fill_drain", b_ack, 0);

        // Four back-to-back reads, responses in order
        b_req(1, 1, 0, 16'h0004, 32'h0, 4'hF, 4'h1);
        tick();
        chk("b_bb_c1", b_ack, 0);
        b_req(1, 1, 0, 16'h0005, 32'h0, 4'hF, 4'h2);
        tick();
        chk("b_bb_c2", b_ack, 0);
        b_req(1, 1, 0, 16'h0006, 32'h0, 4'hF, 4'h3);
        tick();
        chk("b_bb_r1_ack", b_ack, 1);
        chk("b_bb_r1_dat", b_dato, 32'h1122FF44);
        chk("b_bb_r1_tgd", b_tgdo, 4'h1);
        b_req(1, 1, 0, 16'h0007, 32'h0, 4'hF, 4'h4);
        tick();
        chk("b_bb_r2_ack", b_ack, 1);
        chk("b_bb_r2_dat", b_dato, 32'h55555555);
        chk("b_bb_r2_tgd", b_tgdo, 4'h2);
        b_req(1, 0, 0, 16'h0, 32'h0, 4'h0, 4'h0);
        tick();
        chk("b_bb_r3_ack", b_ack, 1);
        chk("b_bb_r3_dat", b_dato, 32'h66666666);
        chk("b_bb_r3_tgd", b_tgdo, 4'h3);
        tick();
        chk("b_bb_r4_ack", b_ack, 1);
        chk("b_bb_r4_dat", b_dato, 32'h77777777);
        chk("b_bb_r4_tgd", b_tgdo, 4'h4);
        tick();
        chk("b_bb_done", b_ack, 0);

        // Drop CYC with two reads in flight
        b_req(1, 1, 0, 16'h0005, 32'h0, 4'hF, 4'h5);
        tick();
        b_req(1, 1, 0, 16'h0006, 32'h0, 4'hF, 4'h6);
        tick();
        chk("b_ab_c2", b_ack, 0);
        b_req(0, 0, 0, 16'h0, 32'h0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_ab_noack", b_ack, 0);
            chk("b_ab_noerr", b_err, 0);
        end
        chk("b_ab_dat", b_dato, 32'h77777777);
        b_req(1, 1, 0, 16'h0008, 32'h0, 4'hF, 4'hA);
        tick();
        b_req(1, 0, 0, 16'h0, 32'h0, 4'h0, 4'h0);
        tick();
        chk("b_ab_wait", b_ack, 0);
        tick();
        chk("b_ab_rd_ack", b_ack, 1);
        chk("b_ab_rd_dat", b_dato, 32'hCAFEF00D);
        chk("b_ab_rd_tgd", b_tgdo, 4'hA);
        chk("b_rty", b_rty, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_target_ram.md
WISHBONE_TARGET_RAM -- requirements
Module: wishbone_target_ram

Interface
REQ-001 SHALL have parameter AddressWidth, 16, word address width.
REQ-002 SHALL have parameter DataWidth, 8, data width in bits (8/16/32/64).
REQ-003 SHALL have parameter Granularity, 8, bits per SEL lane; SELWidth = DataWidth/Granularity.
REQ-004 SHALL have parameter TGDWidth, 1, data tag width.
REQ-005 SHALL have parameter Depth, 256, words of storage (power of two, at most 2**AddressWidth).
REQ-006 SHALL have parameter WaitStates, 0, extra response latency cycles (0..7).
REQ-007 SHALL have ports (one clock; reset asynchronous, active-high):
  CLK  in  1  clock, all logic on rising edge
  RST  in  1  asynchronous active-high reset
  CYC  in  1  bus cycle valid
  STB  in  1  request strobe
  WE  in  1  1 = write, 0 = read
  ADDR  in  AddressWidth  word address
  SEL  in  SELWidth  lane enables
  DAT_ToTarget  in  DataWidth  write data
  TGD_ToTarget  in  TGDWidth  request tag
  ForceStall  in  1  external stall request
  DAT_ToInitiator  out  DataWidth  read data
  TGD_ToInitiator  out  TGDWidth  echoed tag
  ACK  out  1  normal termination
  ERR  out  1  error termination
  RTY  out  1  retry termination, constant 0
  STALL  out  1  pipelined stall

Function
REQ-008 SHALL accept a request in any cycle where CYC & STB & !STALL.
REQ-009 SHALL drive STALL = ForceStall, combinationally.
REQ-010 SHALL commit an accepted write in its accept cycle, writing only lanes with SEL bit set.
REQ-011 SHALL sample read data in the accept cycle; a write and a read to the same address in consecutive cycles SHALL return the new data.
REQ-012 SHALL assert exactly one of ACK/ERR for exactly one cycle, 1+WaitStates cycles after acceptance.
REQ-013 SHALL accept one request per cycle with responses in acceptance order; up to 1+WaitStates responses in flight.
REQ-014 SHALL return DAT_ToInitiator valid only in an ACK cycle of a read; DAT_ToInitiator holds its last value otherwise.
REQ-015 SHALL echo the accepted TGD_ToTarget on TGD_ToInitiator in the response cycle.
REQ-016 SHALL squash all in-flight responses the cycle CYC is sampled low; no ACK/ERR SHALL follow. Writes already committed SHALL remain.
REQ-017 SHALL use a SEL of all zeros as a no-op write/read that still ACKs.
REQ-018 SHALL index storage with ADDR[log2(Depth)-1:0].

Reset
REQ-019 SHALL on RST clear ACK, ERR, RTY, DAT_ToInitiator, TGD_ToInitiator and the in-flight pipeline to 0.
REQ-020 SHALL not clear storage on reset; RST mid-transaction SHALL drop pending responses.

Configuration
REQ-021 SHALL, with WISHBONE_TARGET_RAM_ERR_EN defined, answer any request with ADDR >= Depth by ERR, without writing.
REQ-022 SHALL, without WISHBONE_TARGET_RAM_ERR_EN, ignore upper ADDR bits and alias, never asserting ERR.

Structure
REQ-023 SHALL take the CTI/BTE enums and the response token typedef (valid, is_err, is_read, tgd) from shared package wishbone_pkg.
REQ-024 SHALL place the response delay line in sub-module wishbone_response_pipe (depth 1+WaitStates, synchronous flush input).

Verification
REQ-025 The bench SHALL cover these scenarios:
- WaitStates=0: write 0xA5 @0x10, then read @0x10 -> ACK one cycle after each accept; read returns 0xA5, with TGD echoed.
- DataWidth=32: write 0x11223344 @4, then write 0xFFFFFFFF with SEL=4'b0010, then read @4 -> 0x1122FF44.
- WaitStates=2: four back-to-back reads -> four ACKs on consecutive cycles, starting 3 cycles after the first accept, in order.
- ForceStall=1 for 3 cycles with STB held -> no accept and no ACK; accept occurs on the first cycle after release.
- WaitStates=2: drop CYC one cycle after 2 reads are accepted -> zero ACKs; an earlier write remains readable.
- ERR_EN defined, Depth=256: write @0x0100 -> ERR pulse, no ACK; read @0x0000 unchanged. Undefined: same access ACKs and aliases @0x0000.
